// File: rtl/xunit_f.sv
// SHA-256 compression-round engine: loads a working state after a programmable
// delay following a run pulse, then computes one round per clock indefinitely.
module xunit_f #(
  parameter int DATA_W  = 32,
  parameter int DELAY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               run,
  input  logic [DATA_W-1:0]  in0,
  input  logic [DATA_W-1:0]  in1,
  input  logic [DATA_W-1:0]  in2,
  input  logic [DATA_W-1:0]  in3,
  input  logic [DATA_W-1:0]  in4,
  input  logic [DATA_W-1:0]  in5,
  input  logic [DATA_W-1:0]  in6,
  input  logic [DATA_W-1:0]  in7,
  input  logic [DATA_W-1:0]  in8,
  input  logic [DATA_W-1:0]  in9,
  input  logic [DELAY_W-1:0] delay0,
  output logic [DATA_W-1:0]  out0,
  output logic [DATA_W-1:0]  out1,
  output logic [DATA_W-1:0]  out2,
  output logic [DATA_W-1:0]  out3,
  output logic [DATA_W-1:0]  out4,
  output logic [DATA_W-1:0]  out5,
  output logic [DATA_W-1:0]  out6,
  output logic [DATA_W-1:0]  out7
);

  // ST_WAIT covers both the delay countdown and the pending initial load.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RUN
  } state_t;

  // Element 0 is word a, element 7 is word h.
  typedef logic [7:0][DATA_W-1:0] work_t;

  function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (DATA_W - n));
  endfunction

  function automatic work_t sha_round(input work_t s,
                                      input logic [DATA_W-1:0] w,
                                      input logic [DATA_W-1:0] k);
    logic [DATA_W-1:0] s1, ch, t1, s0, maj, t2;
    work_t r;
    s1  = rotr(s[4], 6) ^ rotr(s[4], 11) ^ rotr(s[4], 25);
    ch  = (s[4] & s[5]) ^ (~s[4] & s[6]);
    t1  = s[7] + s1 + ch + k + w;
    s0  = rotr(s[0], 2) ^ rotr(s[0], 13) ^ rotr(s[0], 22);
    maj = (s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]);
    t2  = s0 + maj;
    r[0] = t1 + t2;
    r[1] = s[0];
    r[2] = s[1];
    r[3] = s[2];
    r[4] = s[3] + t1;
    r[5] = s[4];
    r[6] = s[5];
    r[7] = s[6];
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [DELAY_W-1:0] cnt_q, cnt_d;
  work_t              work_q, work_d;
  work_t              in_vec, round_src, round_res;

  assign in_vec = {in7, in6, in5, in4, in3, in2, in1, in0};

  // The first round after the delay takes its state from the inputs; every
  // later round chains from the registered result.
  assign round_src = (state_q == ST_RUN) ? work_q : in_vec;
  assign round_res = sha_round(round_src, in8, in9);

  // NOTE: every signal assigned here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    if (run) begin
      cnt_d   = delay0;
      state_d = ST_WAIT;
    end else begin
      unique case (state_q)
        ST_WAIT: begin
          if (cnt_q != '0) begin
            cnt_d = cnt_q - DELAY_W'(1);
          end else begin
            work_d  = round_res;
            state_d = ST_RUN;
          end
        end
        ST_RUN:  work_d = round_res;
        default: ;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  assign out0 = work_q[0];
  assign out1 = work_q[1];
  assign out2 = work_q[2];
  assign out3 = work_q[3];
  assign out4 = work_q[4];
  assign out5 = work_q[5];
  assign out6 = work_q[6];
  assign out7 = work_q[7];

endmodule

// File: tb/tb_xunit_f.sv
// Self-checking bench for xunit_f: directed FIPS-180 vectors plus randomized
// run/delay/data traffic compared against a cycle-scheduled SHA-256 model.
module tb_xunit_f;

  logic        clk;
  logic        rst;
  logic        run;
  logic [7:0]  delay0;
  logic [31:0] in_w [10];
  logic [31:0] out_w [8];

  int vec_cnt;
  int err_cnt;

  // Reference model: working state plus the absolute cycle of the next load.
  bit [31:0] mdl [8];
  int        cyc;
  int        load_at;
  bit        mdl_running;

  localparam bit [31:0] K_TAB [16] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174};

  localparam bit [31:0] H_INIT [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  xunit_f dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .in0   (in_w[0]),
    .in1   (in_w[1]),
    .in2   (in_w[2]),
    .in3   (in_w[3]),
    .in4   (in_w[4]),
    .in5   (in_w[5]),
    .in6   (in_w[6]),
    .in7   (in_w[7]),
    .in8   (in_w[8]),
    .in9   (in_w[9]),
    .delay0(delay0),
    .out0  (out_w[0]),
    .out1  (out_w[1]),
    .out2  (out_w[2]),
    .out3  (out_w[3]),
    .out4  (out_w[4]),
    .out5  (out_w[5]),
    .out6  (out_w[6]),
    .out7  (out_w[7])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic bit [31:0] ror(input bit [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  task automatic ref_round(input bit [31:0] a, b, c, d, e, f, g, h, w, k);
    bit [31:0] t1, t2;
    t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    mdl[0] = t1 + t2;
    mdl[1] = a;
    mdl[2] = b;
    mdl[3] = c;
    mdl[4] = d + t1;
    mdl[5] = e;
    mdl[6] = f;
    mdl[7] = g;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mdl[i] = '0;
    load_at     = -1;
    mdl_running = 1'b0;
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_out%0d", tag, i), out_w[i], mdl[i]);
  endtask

  task automatic check_zero(input string tag);
    for (int i = 0; i < 8; i++) check($sformatf("%s_out%0d", tag, i), out_w[i], 32'h0);
  endtask

  // One rising edge: advance the model with the inputs seen at the edge, then
  // compare all outputs 1 ns later.
  task automatic step(input string tag);
    @(posedge clk);
    if (!rst) begin
      model_clear();
    end else if (run) begin
      load_at     = cyc + 1 + int'(delay0);
      mdl_running = 1'b0;
    end else if (cyc == load_at) begin
      ref_round(in_w[0], in_w[1], in_w[2], in_w[3], in_w[4], in_w[5], in_w[6], in_w[7],
                in_w[8], in_w[9]);
      load_at     = -1;
      mdl_running = 1'b1;
    end else if (mdl_running) begin
      ref_round(mdl[0], mdl[1], mdl[2], mdl[3], mdl[4], mdl[5], mdl[6], mdl[7],
                in_w[8], in_w[9]);
    end
    cyc++;
    #1;
    check_model(tag);
  endtask

  task automatic load_abc();
    for (int i = 0; i < 8; i++) in_w[i] = H_INIT[i];
    in_w[8] = 32'h61626380;
    in_w[9] = K_TAB[0];
  endtask

  task automatic randomize_data();
    for (int i = 0; i < 10; i++) in_w[i] = $urandom;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    model_clear();
    check_zero("rst_async");
    step("rst_held");
    rst = 1'b1;
  endtask

  // Message schedule of the padded one-block "abc" message, words 0..15.
  function automatic bit [31:0] abc_w(input int t);
    if (t == 0)  return 32'h61626380;
    if (t == 15) return 32'h00000018;
    return 32'h0;
  endfunction

  bit [31:0] exp_v [8];

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    cyc     = 0;
    model_clear();
    rst    = 1'b0;
    run    = 1'b0;
    delay0 = '0;
    for (int i = 0; i < 10; i++) in_w[i] = '0;

    #2;
    check_zero("reset_state");
    @(posedge clk); cyc++;
    #1;
    rst = 1'b1;
    randomize_data();
    for (int n = 0; n < 4; n++) step("idle_before_run");

    // All-zero state and round inputs produce an all-zero round.
    for (int i = 0; i < 10; i++) in_w[i] = '0;
    run = 1'b1;
    step("zero_run_edge");
    run = 1'b0;
    step("zero_vec");
    check_zero("zero_vec_const");

    // FIPS "abc" rounds 0..15, back to back.
    do_reset();
    #1;
    load_abc();
    run = 1'b1;
    step("abc_run_edge");
    run = 1'b0;
    step("abc_r0");
    exp_v = '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
              32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab};
    for (int i = 0; i < 8; i++) check($sformatf("abc_r0_const%0d", i), out_w[i], exp_v[i]);
    for (int t = 1; t < 16; t++) begin
      for (int i = 0; i < 8; i++) in_w[i] = $urandom;
      in_w[8] = abc_w(t);
      in_w[9] = K_TAB[t];
      step($sformatf("abc_r%0d", t));
      if (t == 1) begin
        exp_v = '{32'h5a6ad9ad, 32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85,
                  32'h78ce7989, 32'hfa2a4622, 32'h510e527f, 32'h9b05688c};
        for (int i = 0; i < 8; i++) check($sformatf("abc_r1_const%0d", i), out_w[i], exp_v[i]);
      end
    end

    // Delay of 3: outputs stay at zero for three edges, round 0 on the fourth.
    do_reset();
    #1;
    load_abc();
    delay0 = 8'd3;
    run = 1'b1;
    step("dly_run_edge");
    run = 1'b0;
    for (int n = 1; n <= 3; n++) begin
      step($sformatf("dly_wait%0d", n));
      check($sformatf("dly_wait%0d_a", n), out_w[0], 32'h0);
    end
    step("dly_r0");
    check("dly_r0_a_const", out_w[0], 32'h5d6aebcd);
    check("dly_r0_e_const", out_w[4], 32'hfa2a4622);

    // Reset asserted during round 5 clears at once, then the unit stays idle.
    do_reset();
    #1;
    load_abc();
    delay0 = '0;
    run = 1'b1;
    step("mid_run_edge");
    run = 1'b0;
    for (int t = 0; t < 5; t++) begin
      in_w[8] = $urandom;
      in_w[9] = $urandom;
      step($sformatf("mid_r%0d", t));
    end
    #2;
    rst = 1'b0;
    #1;
    model_clear();
    check_zero("mid_rst_async");
    step("mid_rst_held");
    rst = 1'b1;
    randomize_data();
    for (int n = 0; n < 10; n++) step($sformatf("mid_idle%0d", n));

    // Restart while running: hold on the run edge, reload on the next.
    load_abc();
    run = 1'b1;
    step("rs_run_edge");
    run = 1'b0;
    for (int t = 0; t < 8; t++) begin
      in_w[8] = $urandom;
      in_w[9] = $urandom;
      step($sformatf("rs_r%0d", t));
    end
    randomize_data();
    run = 1'b1;
    step("rs_restart_edge");
    run = 1'b0;
    step("rs_reload");
    in_w[8] = $urandom;
    step("rs_continue");

    // run coincident with reset is ignored.
    rst = 1'b0;
    run = 1'b1;
    step("rst_run_edge");
    rst = 1'b1;
    run = 1'b0;
    for (int n = 0; n < 3; n++) step($sformatf("rst_run_idle%0d", n));

    // Randomized traffic: sporadic run pulses with random delays.
    for (int n = 0; n < 600; n++) begin
      randomize_data();
      delay0 = 8'($urandom_range(0, 5));
      run    = ($urandom_range(0, 19) == 0);
      step("rand");
    end
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/xunit_f.md
XUNIT_F -- requirements
Module: xunitF

Interface
REQ-001 Parameter DATA_W, default 32, width of every data port and state word.
REQ-002 Parameter DELAY_W, default 8, width of the delay configuration port.
REQ-003 Port clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port rst  input  1  reset, asynchronous, active-low (asserted when 0).
REQ-005 Port run  input  1  single-cycle start pulse, sampled on rising clk.
REQ-006 Ports in0..in7  input  DATA_W each  initial SHA-256 working state a,b,c,d,e,f,g,h.
REQ-007 Port in8  input  DATA_W  message schedule word W for the current round.
REQ-008 Port in9  input  DATA_W  round constant K for the current round.
REQ-009 Ports out0..out7  output  DATA_W each  registered working state a..h after the latest round.
REQ-010 Port delay0  input  DELAY_W  number of idle cycles between run and the first round; sampled on the run cycle.

Function
REQ-011 Unit SHALL perform one SHA-256 compression round per clock once started.
REQ-012 Round SHALL compute, all arithmetic modulo 2^DATA_W: S1 = ROTR6(e)^ROTR11(e)^ROTR25(e); Ch = (e&f)^(~e&g); T1 = h+S1+Ch+K+W; S0 = ROTR2(a)^ROTR13(a)^ROTR22(a); Maj = (a&b)^(a&c)^(b&c); T2 = S0+Maj.
REQ-013 Round result SHALL be a'=T1+T2, b'=a, c'=b, d'=c, e'=d+T1, f'=e, g'=f, h'=g, driven on out0..out7 respectively.
REQ-014 On a rising edge with run=1, unit SHALL load an internal delay counter with delay0, set an internal load-pending flag, and leave out0..out7 unchanged.
REQ-015 On each later edge with delay counter nonzero, counter SHALL decrement and outputs SHALL hold.
REQ-016 On the first edge with delay counter zero and load-pending set, round SHALL use in0..in7 as a..h, with in8/in9; result registered to outputs; load-pending cleared; unit enters running state.
REQ-017 In running state, each edge SHALL compute a round using out0..out7 as a..h and the current in8/in9.
REQ-018 Latency: with delay0=D and run sampled at edge T, first result SHALL appear after edge T+1+D; subsequent results one per cycle.
REQ-019 Running state SHALL continue indefinitely (no internal round count) until reset or the next run.
REQ-020 run asserted while running or delaying SHALL restart: counter reloaded, load-pending set, outputs hold on that edge, next initial load per REQ-016.
REQ-021 Before the first run after reset, outputs SHALL hold their reset value.

Reset
REQ-022 While rst=0, out0..out7 SHALL be 0, delay counter 0, load-pending and running cleared, asynchronously and independent of clk.
REQ-023 Reset asserted mid-operation SHALL abort the sequence; after release the unit SHALL stay idle until the next run.
REQ-024 run=1 coincident with rst=0 SHALL be ignored.

Verification
REQ-025 Zero vector: delay0=0, run, then in0..in9=0 -> after edge T+1 all outputs 0x00000000.
REQ-026 FIPS "abc" round 0: delay0=0, in0..in7 = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19, W=61626380, K=428a2f98 -> outputs 5d6aebcd 6a09e667 bb67ae85 3c6ef372 fa2a4622 510e527f 9b05688c 1f83d9ab.
REQ-027 Round 1 continuation: next cycle W=00000000, K=71374491 -> outputs 5a6ad9ad 5d6aebcd 6a09e667 bb67ae85 78ce7989 fa2a4622 510e527f 9b05688c; 16 consecutive W/K pairs yield 16 back-to-back results, each checked against a software SHA-256 model.
REQ-028 Delay: delay0=3, same stimulus as REQ-026 -> outputs stay 0 for edges T+1..T+3, round-0 result after edge T+4.
REQ-029 Reset mid-run: assert rst=0 during round 5 -> outputs 0 immediately; after release with run low outputs stay 0 over 10 cycles.
REQ-030 Restart: run pulsed during round 8 -> outputs hold for that edge, then next edge loads from in0..in7 per REQ-016.
